// File: rtl/fft_out_reorder.sv
// FFT output reorder: bit-reversed input stream to natural-order frames.
// Ping-pong pair of N-entry banks, valid/ready output with sof/eof markers.
module fft_out_reorder #(
  parameter int N     = 1024,
  parameter int LOG2N = 10,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_re,
  input  logic signed [DW-1:0] in_im,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 overflow
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [LOG2N-1:0] wcnt;
  logic [LOG2N-1:0] rcnt;
  logic             wsel;
  logic             rsel;
  logic [1:0]       full;
  logic             drop;

  logic [2*DW-1:0]  mem [2*N];
  logic [2*DW-1:0]  rdata;

  logic             start;
  logic             drop_now;
  logic             we;
  logic             wlast;
  logic             adv;
  logic             rd;
  logic             rlast;
  logic [1:0]       full_set;
  logic [1:0]       full_clr;

  // drop decision is taken at each frame start and held for the frame
  assign start    = (wcnt == '0);
  assign drop_now = start ? full[wsel] : drop;
  assign we       = in_valid && !drop_now;
  assign wlast    = we && (wcnt == LAST);

  assign adv      = !out_valid || out_ready;
  assign rd       = adv && full[rsel];
  assign rlast    = rd && (rcnt == LAST);

  assign full_set = wlast ? (2'b01 << wsel) : 2'b00;
  assign full_clr = rlast ? (2'b01 << rsel) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt     <= '0;
      wsel     <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else if (in_valid) begin
      wcnt <= wcnt + 1'b1;
      if (start) begin
        drop <= full[wsel];
        if (full[wsel]) begin
          overflow <= 1'b1;
        end
      end
      if (wlast) begin
        wsel <= ~wsel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 2'b00;
    end else begin
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt      <= '0;
      rsel      <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (adv) begin
      out_valid <= full[rsel];
      if (rd) begin
        rcnt    <= rcnt + 1'b1;
        out_sof <= (rcnt == '0);
        out_eof <= (rcnt == LAST);
        if (rlast) begin
          rsel <= ~rsel;
        end
      end
    end
  end

  // banks share one array; the bank select is the address MSB
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wsel, bitrev(wcnt)}] <= {in_re, in_im};
    end
    if (rd) begin
      rdata <= mem[{rsel, rcnt}];
    end
  end

  assign out_re = out_valid ? rdata[2*DW-1:DW] : '0;
  assign out_im = out_valid ? rdata[DW-1:0]    : '0;

endmodule
